// File: rtl/keypad_scan_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a; no handshaking in this block family.
package keypad_scan_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_PRESSED  = 2'd2,
        ST_RELEASE  = 2'd3
    } state_e;

    typedef enum logic [1:0] {
        FR_NONE   = 2'd0,
        FR_SINGLE = 2'd1,
        FR_MULTI  = 2'd2
    } frame_res_e;

    // Number of set bits in a 4-bit vector.
    function automatic logic [2:0] pop4(input logic [3:0] v);
        pop4 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
    endfunction

    // Index of the lowest set bit; only meaningful when exactly one bit is set.
    function automatic logic [1:0] low_idx4(input logic [3:0] v);
        low_idx4 = 2'd0;
        if (v[3]) low_idx4 = 2'd3;
        if (v[2]) low_idx4 = 2'd2;
        if (v[1]) low_idx4 = 2'd1;
        if (v[0]) low_idx4 = 2'd0;
    endfunction

endpackage

// File: rtl/keypad_scan_timer.sv
// Column scan timebase: divides clk into column slots and rotates the active-low strobe.
// Latency: tick/frame_end are combinational decodes of the divider registers.
// Backpressure: none; free-running once clr is released.
// Ports: clk, clr (sync active-high) in; col[3:0] strobe, col_idx[1:0], tick, frame_end out.
module keypad_scan_timer #(
    parameter int SCAN_DIV = 1000
) (
    input  logic       clk,
    input  logic       clr,
    output logic [3:0] col,
    output logic [1:0] col_idx,
    output logic       tick,
    output logic       frame_end
);
    import keypad_scan_pkg::*;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [3:0]    col_q, col_d;

    always_comb begin
        tick      = (div_cnt_q == DIV_LAST);
        frame_end = tick && (col_idx_q == 2'd3);
        div_cnt_d = div_cnt_q + DW'(1);
        col_idx_d = col_idx_q;
        col_d     = col_q;
        if (tick) begin
            div_cnt_d = '0;
            col_idx_d = col_idx_q + 2'd1;
            col_d     = {col_q[2:0], col_q[3]};
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            div_cnt_q <= '0;
            col_idx_q <= 2'd0;
            col_q     <= 4'b1110;
        end else begin
            div_cnt_q <= div_cnt_d;
            col_idx_q <= col_idx_d;
            col_q     <= col_d;
        end
    end

    assign col     = col_q;
    assign col_idx = col_idx_q;

endmodule

// File: rtl/keypad_scan.sv
// 4x4 key matrix scanner with whole-frame debounce and one pulse per accepted press.
// Latency: key_valid rises the cycle after the frame-end tick that completes the debounce run.
// Backpressure: none; key_valid is a fire-and-forget pulse, key_code holds until the next accept.
// Ports: clk, clr (sync active-high), row[3:0] (active-low, async) in;
//        col[3:0] (active-low one-hot), key_code[3:0], key_valid, key_held, state[1:0] out.
module keypad_scan #(
    parameter int SCAN_DIV        = 1000,
    parameter int DEBOUNCE_FRAMES = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic [3:0] row,
    output logic [3:0] col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic [1:0] state
);
    import keypad_scan_pkg::*;

    localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);
    localparam logic [CW-1:0] DF_C   = CW'(DEBOUNCE_FRAMES);
    localparam bit            DF_ONE = (DEBOUNCE_FRAMES == 1);

    logic [1:0] col_idx;
    logic       tick;
    logic       frame_end;

    keypad_scan_timer #(.SCAN_DIV(SCAN_DIV)) u_timer (
        .clk       (clk),
        .clr       (clr),
        .col       (col),
        .col_idx   (col_idx),
        .tick      (tick),
        .frame_end (frame_end)
    );

    // Two-flop synchronizer; idle level (all high) on reset.
    logic [3:0] row_s1_q, row_s2_q;

    always_ff @(posedge clk) begin
        if (clr) begin
            row_s1_q <= 4'hF;
            row_s2_q <= 4'hF;
        end else begin
            row_s1_q <= row;
            row_s2_q <= row_s1_q;
        end
    end

    // Frame accumulator: remembers whether any key and more than one key were seen.
    logic       acc_seen_q,  acc_seen_d;
    logic       acc_multi_q, acc_multi_d;
    logic [3:0] acc_code_q,  acc_code_d;
    logic [3:0] low;
    logic [2:0] low_cnt;
    logic       seen_n, multi_n;
    logic [3:0] code_n;
    frame_res_e fr;

    always_comb begin
        low     = ~row_s2_q;
        low_cnt = pop4(low);
        // Fold this column's sample into the running frame summary.
        seen_n  = acc_seen_q | (low_cnt != 3'd0);
        multi_n = acc_multi_q | (low_cnt > 3'd1) | (acc_seen_q && (low_cnt != 3'd0));
        code_n  = (!acc_seen_q && (low_cnt == 3'd1)) ? {low_idx4(low), col_idx} : acc_code_q;

        acc_seen_d  = acc_seen_q;
        acc_multi_d = acc_multi_q;
        acc_code_d  = acc_code_q;
        if (frame_end) begin
            acc_seen_d  = 1'b0;
            acc_multi_d = 1'b0;
            acc_code_d  = 4'h0;
        end else if (tick) begin
            acc_seen_d  = seen_n;
            acc_multi_d = multi_n;
            acc_code_d  = code_n;
        end

        if (multi_n)      fr = FR_MULTI;
        else if (seen_n)  fr = FR_SINGLE;
        else              fr = FR_NONE;
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            acc_seen_q  <= 1'b0;
            acc_multi_q <= 1'b0;
            acc_code_q  <= 4'h0;
        end else begin
            acc_seen_q  <= acc_seen_d;
            acc_multi_q <= acc_multi_d;
            acc_code_q  <= acc_code_d;
        end
    end

    // Debounce FSM, advanced only at frame end.
    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [3:0]     cand_q, cand_d;
    logic [3:0]     key_code_q, key_code_d;
    logic           key_valid_q, key_valid_d;
    logic           key_held_q, key_held_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cand_d      = cand_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
        key_held_d  = key_held_q;
        cnt_inc     = cnt_q + CW'(1);

        if (frame_end) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (fr == FR_SINGLE) begin
                        cand_d = code_n;
                        if (DF_ONE) begin
                            key_code_d  = code_n;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                        end else begin
                            state_d = ST_DEBOUNCE;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_DEBOUNCE: begin
                    if ((fr == FR_SINGLE) && (code_n == cand_q)) begin
                        if (cnt_inc == DF_C) begin
                            key_code_d  = cand_q;
                            key_valid_d = 1'b1;
                            key_held_d  = 1'b1;
                            state_d     = ST_PRESSED;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end
                end
                ST_PRESSED: begin
                    // Any key activity keeps us here; extra keys are rollover and ignored.
                    if (fr == FR_NONE) begin
                        if (DF_ONE) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                        end else begin
                            state_d = ST_RELEASE;
                            cnt_d   = CW'(1);
                        end
                    end
                end
                ST_RELEASE: begin
                    if (fr == FR_NONE) begin
                        if (cnt_inc == DF_C) begin
                            state_d    = ST_IDLE;
                            key_held_d = 1'b0;
                            cnt_d      = '0;
                        end else begin
                            cnt_d = cnt_inc;
                        end
                    end else begin
                        // Release glitch: key came back, no new pulse.
                        state_d = ST_PRESSED;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            cand_q      <= 4'h0;
            key_code_q  <= 4'h0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cand_q      <= cand_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign state     = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with a small key-matrix model driving row from col.
// Latency: frames are 16 cycles (SCAN_DIV=4); all steps are aligned to frame boundaries.
// Backpressure: n/a.
module tb_keypad_scan;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [3:0] row;
    logic [3:0] col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic [1:0] state;

    logic [15:0] keys = 16'h0;   // bit index = {row_idx, col_idx}
    int checks   = 0;
    int failures = 0;
    int pulse_cnt = 0;
    int base;

    keypad_scan #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
        .clk       (clk),
        .clr       (clr),
        .row       (row),
        .col       (col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .state     (state)
    );

    always #5 clk = ~clk;

    // Matrix model: a pressed key pulls its row low while its column is strobed.
    always_comb begin
        row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[r*4+c] && !col[c]) row[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (key_valid === 1'b1) pulse_cnt <= pulse_cnt + 1;
    end

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic frames(input int n);
        repeat (16 * n) @(negedge clk);
    endtask

    task automatic pulse_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        // Reset
        repeat (2) @(negedge clk);
        clr = 1'b0;
        check("rst_col", {4'h0, col}, 8'h0E);
        check("rst_valid", {7'h0, key_valid}, 8'h00);
        check("rst_held", {7'h0, key_held}, 8'h00);
        check("rst_state", {6'h0, state}, 8'h00);
        check("rst_code", {4'h0, key_code}, 8'h00);
        repeat (3) @(negedge clk);
        check("col_hold", {4'h0, col}, 8'h0E);
        @(negedge clk);
        check("col_step", {4'h0, col}, 8'h0D);
        repeat (12) @(negedge clk);

        // Stable press of row2/col1
        base = pulse_cnt;
        keys = 16'h0200;
        frames(2);
        check("press_debounce_state", {6'h0, state}, 8'h01);
        check("press_early_held", {7'h0, key_held}, 8'h00);
        frames(1);
        check("press_valid", {7'h0, key_valid}, 8'h01);
        check("press_code", {4'h0, key_code}, 8'h09);
        check("press_held", {7'h0, key_held}, 8'h01);
        check("press_state", {6'h0, state}, 8'h02);
        frames(10);
        check("press_pulses", 8'(pulse_cnt - base), 8'h01);

        // One-frame release glitch
        keys = 16'h0000;
        frames(1);
        check("glitch_state_rel", {6'h0, state}, 8'h03);
        keys = 16'h0200;
        frames(1);
        check("glitch_state_back", {6'h0, state}, 8'h02);
        check("glitch_held", {7'h0, key_held}, 8'h01);

        // Real release
        keys = 16'h0000;
        frames(2);
        check("rel_held_early", {7'h0, key_held}, 8'h01);
        check("rel_state_early", {6'h0, state}, 8'h03);
        frames(1);
        check("rel_held", {7'h0, key_held}, 8'h00);
        check("rel_state", {6'h0, state}, 8'h00);
        check("rel_code_kept", {4'h0, key_code}, 8'h09);
        check("rel_pulses", 8'(pulse_cnt - base), 8'h01);

        // Bounce: one frame on, one frame off
        base = pulse_cnt;
        for (int i = 0; i < 6; i++) begin
            keys = 16'h0200;
            frames(1);
            check("bounce_on_state", {6'h0, state}, 8'h01);
            keys = 16'h0000;
            frames(1);
            check("bounce_off_state", {6'h0, state}, 8'h00);
        end
        check("bounce_pulses", 8'(pulse_cnt - base), 8'h00);

        // Two keys 0x0 and 0x5, then drop 0x5
        base = pulse_cnt;
        keys = 16'h0021;
        frames(3);
        check("multi_state", {6'h0, state}, 8'h00);
        check("multi_pulses", 8'(pulse_cnt - base), 8'h00);
        keys = 16'h0001;
        frames(2);
        check("drop_debounce", {6'h0, state}, 8'h01);
        frames(1);
        check("drop_valid", {7'h0, key_valid}, 8'h01);
        check("drop_code", {4'h0, key_code}, 8'h00);
        keys = 16'h0000;
        frames(3);
        check("drop_rel_state", {6'h0, state}, 8'h00);
        check("drop_pulses", 8'(pulse_cnt - base), 8'h01);

        // clr during DEBOUNCE (mid-frame), key held throughout
        base = pulse_cnt;
        keys = 16'h8000;
        frames(2);
        check("clr1_pre_state", {6'h0, state}, 8'h01);
        repeat (5) @(negedge clk);
        pulse_clr();
        check("clr1_state", {6'h0, state}, 8'h00);
        check("clr1_held", {7'h0, key_held}, 8'h00);
        check("clr1_col", {4'h0, col}, 8'h0E);
        frames(2);
        check("clr1_redeb", {6'h0, state}, 8'h01);
        frames(1);
        check("clr1_valid", {7'h0, key_valid}, 8'h01);
        check("clr1_code", {4'h0, key_code}, 8'h0F);
        frames(1);
        check("clr2_pre_state", {6'h0, state}, 8'h02);

        // clr during PRESSED, key still held
        pulse_clr();
        check("clr2_state", {6'h0, state}, 8'h00);
        check("clr2_held", {7'h0, key_held}, 8'h00);
        check("clr2_code", {4'h0, key_code}, 8'h00);
        frames(2);
        check("clr2_no_held", {7'h0, key_held}, 8'h00);
        frames(1);
        check("clr2_valid", {7'h0, key_valid}, 8'h01);
        check("clr2_code_acc", {4'h0, key_code}, 8'h0F);
        check("clr2_held_acc", {7'h0, key_held}, 8'h01);
        keys = 16'h0000;
        frames(4);
        check("clr_final_state", {6'h0, state}, 8'h00);
        check("clr_pulses", 8'(pulse_cnt - base), 8'h02);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
